// File: rtl/pipe_power_pkg.sv
// pipe_power_pkg
//   Shared defaults and arithmetic helpers for the pipe_power power unit.
//   Stage payloads depend on module parameters, so each module declares its
//   own payload struct. payload_w() keeps the packed width identical
//   everywhere that payload crosses a port.
//   mul_ovf() works on MUL_MAX_W-bit operands with a runtime width. Callers
//   pass a parameter for that width, so the unused high part is constant
//   and is optimised away.
package pipe_power_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MAX_EXP = 7;
  localparam int DEF_TAG_W   = 4;
  localparam int MUL_MAX_W   = 64;

  // Packed width of {valid, acc, base, exp, tag, ovf}
  function automatic int payload_w(input int width, input int exp_w, input int tag_w);
    return 2 + 2 * width + exp_w + tag_w;
  endfunction

  // Returns {overflow, low product}.
  // The low product is masked to `width` bits.
  // Overflow is set when any product bit at or above `width` is set.
  function automatic logic [MUL_MAX_W:0] mul_ovf(input logic [MUL_MAX_W-1:0] a,
                                                 input logic [MUL_MAX_W-1:0] b,
                                                 input int unsigned          width);
    logic [2*MUL_MAX_W-1:0] prod;
    logic [2*MUL_MAX_W-1:0] upper;
    logic [MUL_MAX_W-1:0]   mask;
    prod  = {{MUL_MAX_W{1'b0}}, a} * {{MUL_MAX_W{1'b0}}, b};
    upper = prod >> width;
    mask  = ~({MUL_MAX_W{1'b1}} << width);
    return {|upper, prod[MUL_MAX_W-1:0] & mask};
  endfunction

endpackage

// File: rtl/pipe_power_stage.sv
// power_stage
//   One register stage of the power pipeline.
//   Stage K multiplies the accumulator by the base when K <= exp.
//   In that case it also folds any lost high product bits into the sticky
//   overflow flag. Otherwise the accumulator passes through unchanged.
// Ports
//   clock, reset  rising-edge clock, async active-high reset
//   enable        global advance; the stage holds when low
//   d             payload from the previous stage (or the stage-0 load)
//   q             registered payload for the next stage
module power_stage
  import pipe_power_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int MAX_EXP = DEF_MAX_EXP,
  parameter  int TAG_W   = DEF_TAG_W,
  parameter  int K       = 1,
  localparam int EXP_W   = $clog2(MAX_EXP + 1),
  localparam int PAY_W   = payload_w(WIDTH, EXP_W, TAG_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [PAY_W-1:0] d,
  output logic [PAY_W-1:0] q
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } stage_t;

  stage_t               cur;
  stage_t               nxt;
  stage_t               held;
  logic [MUL_MAX_W-1:0] acc_ext;
  logic [MUL_MAX_W-1:0] base_ext;
  logic [MUL_MAX_W:0]   prod;
  logic                 take;
  logic                 unused_prod_bits;

  assign cur = d;

  // Conditional multiply; overflow is sticky for the whole transaction
  always_comb begin
    acc_ext                 = '0;
    base_ext                = '0;
    acc_ext[WIDTH-1:0]      = cur.acc;
    base_ext[WIDTH-1:0]     = cur.base;
    prod                    = mul_ovf(acc_ext, base_ext, WIDTH);
    take                    = (int'(cur.exp) >= K);
    nxt                     = cur;
    if (take) begin
      nxt.acc = prod[WIDTH-1:0];
      nxt.ovf = cur.ovf | prod[MUL_MAX_W];
    end
  end

  // Bubbles only clear the valid bit; data of empty slots is left alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held <= '0;
    end else if (enable) begin
      if (cur.valid) begin
        held <= nxt;
      end else begin
        held.valid <= 1'b0;
      end
    end
  end

  assign q                = held;
  assign unused_prod_bits = ^prod;

endmodule

// File: rtl/pipe_power.sv
// pipe_power
//   Fully pipelined result = base**exp mod 2**WIDTH.
//   It has MAX_EXP register stages and a per-transaction exponent.
//   A single global stall applies valid/ready backpressure to all stages.
// Ports
//   clock, reset         rising-edge clock, async active-high reset
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_base/exp/tag      operand, exponent and passthrough tag
//   out_valid/out_ready  output handshake
//   out_result           low WIDTH bits of base**exp
//   out_overflow         true result exceeded WIDTH bits, or exp > MAX_EXP
//   out_tag              tag of the transaction on out_result
module pipe_power
  import pipe_power_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int MAX_EXP = DEF_MAX_EXP,
  parameter  int TAG_W   = DEF_TAG_W,
  localparam int EXP_W   = $clog2(MAX_EXP + 1),
  localparam int PAY_W   = payload_w(WIDTH, EXP_W, TAG_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_base,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } stage_t;

  stage_t           load;
  stage_t           last;
  logic [PAY_W-1:0] stage_q [1:MAX_EXP];
  logic             adv;
  logic             unused_last;

  // Stage 0: start the accumulator at 1.
  // Out-of-range exponents are clamped to MAX_EXP and flagged as overflow
  // from the start.
  always_comb begin
    load       = '0;
    load.valid = in_valid;
    load.acc   = WIDTH'(1);
    load.base  = in_base;
    load.tag   = in_tag;
    if (int'(in_exp) > MAX_EXP) begin
      load.exp = EXP_W'(MAX_EXP);
      load.ovf = 1'b1;
    end else begin
      load.exp = in_exp;
    end
  end

  for (genvar k = 1; k <= MAX_EXP; k++) begin : g_stage
    logic [PAY_W-1:0] d_k;
    if (k == 1) begin : g_first
      assign d_k = load;
    end else begin : g_rest
      assign d_k = stage_q[k-1];
    end
    power_stage #(
      .WIDTH  (WIDTH),
      .MAX_EXP(MAX_EXP),
      .TAG_W  (TAG_W),
      .K      (k)
    ) u_stage (
      .clock (clock),
      .reset (reset),
      .enable(adv),
      .d     (d_k),
      .q     (stage_q[k])
    );
  end

  // The whole pipe moves only when the last slot is empty or being taken
  assign last         = stage_q[MAX_EXP];
  assign adv          = ~last.valid | out_ready;
  assign in_ready     = adv;
  assign out_valid    = last.valid;
  assign out_result   = last.acc;
  assign out_overflow = last.ovf;
  assign out_tag      = last.tag;
  assign unused_last  = ^{last.base, last.exp};

endmodule
